// File: rtl/mem_arbiter.sv
// Arbiter for the single-port 256x8 unified memory shared by instruction fetch
// (read-only) and the load/store unit. The LSU has priority, and a starvation
// counter guarantees that instruction fetch still makes progress.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       if_req_valid,
  input  logic [7:0] if_req_addr,
  output logic       if_req_ready,
  output logic       if_resp_valid,
  output logic [7:0] if_resp_data,
  input  logic       ls_req_valid,
  input  logic       ls_req_wr,
  input  logic [7:0] ls_req_addr,
  input  logic [7:0] ls_req_wdata,
  output logic       ls_req_ready,
  output logic       ls_resp_valid,
  output logic [7:0] ls_resp_data,
  output logic       mem_enable,
  output logic       mem_wr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a requester holds valid/addr/data stable until it sees ready=1
  // in the same cycle. That cycle is the transfer. The matching response
  // arrives exactly one cycle later and cannot be back-pressured.

  logic       if_eligible;
  logic       grant_if;
  logic       grant_ls;
  logic [3:0] starve_cnt;
  logic       if_resp_q;
  logic       ls_resp_q;
  logic [7:0] if_data_q;
  logic [7:0] ls_data_q;

  assign if_eligible = if_req_valid & ~flush;

  // The LSU wins unless fetch has already waited through STARVE_LIMIT LSU grants.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!rst) begin
      if (ls_req_valid && !(if_eligible && (starve_cnt == LIMIT))) begin
        grant_ls = 1'b1;
      end else if (if_eligible) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 8'h00;
    mem_wdata  = 8'h00;
    if (grant_ls) begin
      mem_enable = 1'b1;
      mem_wr     = ls_req_wr;
      mem_addr   = ls_req_addr;
      mem_wdata  = ls_req_wdata;
    end else if (grant_if) begin
      mem_enable = 1'b1;
      mem_addr   = if_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_if || !if_eligible) begin
      starve_cnt <= 4'd0;
    end else if (grant_ls) begin
      starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end
  end

  // Data registers fall back to zero whenever their port was not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_q <= 1'b0;
      ls_resp_q <= 1'b0;
      if_data_q <= 8'h00;
      ls_data_q <= 8'h00;
    end else begin
      if_resp_q <= grant_if;
      ls_resp_q <= grant_ls;
      if_data_q <= grant_if ? mem_rdata : 8'h00;
      ls_data_q <= (grant_ls && !ls_req_wr) ? mem_rdata : 8'h00;
    end
  end

  // Masking with rst drops the response of a grant made just before reset.
  assign if_resp_valid = if_resp_q & ~flush & ~rst;
  assign if_resp_data  = rst ? 8'h00 : if_data_q;
  assign ls_resp_valid = ls_resp_q & ~rst;
  assign ls_resp_data  = rst ? 8'h00 : ls_data_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port 256x8 unified memory between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- LSU has priority; a starvation counter guarantees IF forward progress.
- Drives the memory's enable/wr/addr/data pins and returns registered responses one cycle after grant.
- Enforces "no concurrent read and write" and keeps the memory idle during reset while its image loads.

Parameters:
STARVE_LIMIT, 4, max consecutive LSU grants while IF is waiting before IF is forced a grant (legal 1..15; 1 gives strict alternation)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; kills IF grant and IF response this cycle
if_req_valid  in  1  IF read request
if_req_addr  in  8  IF byte address
if_req_ready  out  1  IF request accepted this cycle (combinational)
if_resp_valid  out  1  IF read data valid
if_resp_data  out  8  IF read data
ls_req_valid  in  1  LSU request
ls_req_wr  in  1  1=store, 0=load
ls_req_addr  in  8  LSU byte address
ls_req_wdata  in  8  store data
ls_req_ready  out  1  LSU request accepted this cycle (combinational)
ls_resp_valid  out  1  LSU load data / store ack valid
ls_resp_data  out  8  load data; 0x00 for store ack
mem_enable  out  1  memory enable
mem_wr  out  1  memory write strobe
mem_addr  out  8  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory combinational read data

Behaviour:
- Grant (combinational, cycle N):
  - rst=1: no grant.
  - Else if ls_req_valid and not (if_eligible and starve_cnt==STARVE_LIMIT): grant LSU.
  - Else if if_eligible: grant IF.
  - Else: no grant.
  - if_eligible = if_req_valid & ~flush.
- At most one grant per cycle. Granted port's ready=1; the other port's ready=0. Requesters hold valid/addr/data until ready.
- Memory pins:
  - LSU grant: mem_enable=1, mem_wr=ls_req_wr, mem_addr=ls_req_addr, mem_wdata=ls_req_wdata.
  - IF grant: mem_enable=1, mem_wr=0, mem_addr=if_req_addr, mem_wdata=0.
  - No grant: all zero.
- starve_cnt (4-bit register), updated on clock edge:
  - rst: 0.
  - IF grant: 0.
  - LSU grant with if_eligible: +1, saturating at STARVE_LIMIT.
  - if_eligible=0: 0.
- Responses: registered, latency 1.
  - Grant in cycle N: resp_valid=1 in cycle N+1 only.
  - Read data = mem_rdata sampled at the end of cycle N.
  - Store ack: ls_resp_data=0x00.
  - A store at N followed by a load of the same address at N+1 returns the new data.
  - Both ports may show resp_valid only in different cycles; simultaneous responses are impossible.
- No response back-pressure: requesters must accept resp_valid when it appears.
- Flush:
  - if_resp_valid = if_resp_q & ~flush, so flush in N+1 kills the IF response of a grant made in N.
  - flush never affects the LSU.
  - if_resp_data is still updated.
- Reset:
  - All response registers and starve_cnt cleared; all outputs read 0 while rst=1.
  - mem_enable=0 throughout rst, so no writes occur during image load.
  - A grant in the cycle before rst produces no response.
  - The first grant is possible in the first cycle after rst deasserts.
- Idle: registered resp_valid=0 and resp_data=0 in any cycle following a no-grant cycle.

Test Plan:
- Preload mem[0x10]=0xA5; IF alone requests 0x10 -> if_req_ready=1, mem_enable=1, mem_wr=0 same cycle; next cycle if_resp_valid=1, data=0xA5; then 0.
- LSU store 0x20<=0x3C, then load 0x20 back-to-back -> mem_wr=1 then 0; ls_resp_valid in both following cycles; data 0x00 then 0x3C.
- Both ports request continuously, STARVE_LIMIT=4 -> grant sequence LSU,LSU,LSU,LSU,IF repeating; IF response every 5th cycle; never two ready in one cycle.
- Same with STARVE_LIMIT=1 -> strict LSU/IF alternation.
- IF granted in N, flush=1 in N+1 while IF still requesting -> if_resp_valid=0 in N+1, no IF grant in N+1; LSU request in N+1 granted normally with ls_resp_valid in N+2.
- rst held 3 cycles with both ports requesting -> both ready, mem_enable and resp_valid all 0; rst asserted the cycle after an LSU load grant -> ls_resp_valid=0; first cycle after rst deassert -> LSU granted.
